// File: rtl/bw_mul_arbiter_if.sv
// Handshake bundle between the two requesters, the response consumer and
// the shared multiplier arbiter. Operand and product buses carry
// two's-complement values; signedness is applied inside the arbiter.
interface bw_mul_arbiter_if #(
  parameter int WIDTH = 3
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_x0;
  logic [WIDTH-1:0]   req_y0;
  logic [WIDTH-1:0]   req_x1;
  logic [WIDTH-1:0]   req_y1;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_id;

  // Client side: requesters plus the response consumer.
  modport master (
    output req_valid, req_x0, req_y0, req_x1, req_y1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_x0, req_y0, req_x1, req_y1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/bw_mul_arbiter.sv
// Round-robin arbiter sharing one combinational Baugh-Wooley signed
// multiplier between two requesters. A granted request latches its
// operands, the product is registered one cycle later and then held on the
// response channel, tagged with the requester ID, until it is consumed.
module bw_mul_arbiter #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bw_mul_arbiter_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PW = 2 * WIDTH;
  // Correction constant of the modified Baugh-Wooley array: +2^W + 2^(2W-1).
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             id_q, id_d;
  logic             rr_last_q, rr_last_d;
  logic [PW-1:0]    rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic [1:0]       grant;
  logic [PW-1:0]    bw_sum;
  logic             pp;

  // Round-robin pick: on contention the requester that did not win last.
  always_comb begin
    grant = 2'b00;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Baugh-Wooley core: partial products that pair exactly one sign bit with
  // a magnitude bit are inverted, and the correction constant is added.
  always_comb begin
    bw_sum = '0;
    pp     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = x_q[i] & y_q[j];
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp = ~pp;
        bw_sum = bw_sum + ({{(PW-1){1'b0}}, pp} << (i + j));
      end
    end
    bw_sum = bw_sum + BW_CONST;
  end

  // Next-state, operand capture, product register and completion count.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    id_d          = id_q;
    rr_last_d     = rr_last_q;
    rsp_data_d    = rsp_data_q;
    done_cnt_d    = done_cnt_q;
    bus.req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        // Ready follows the grant, so it never rises without its valid.
        bus.req_ready = rst_n ? grant : 2'b00;
        if (grant != 2'b00) begin
          id_d      = grant[1];
          rr_last_d = grant[1];
          x_d       = grant[1] ? bus.req_x1 : bus.req_x0;
          y_d       = grant[1] ? bus.req_y1 : bus.req_y0;
          state_d   = MUL;
        end
      end
      MUL: begin
        rsp_data_d = bw_sum;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      rsp_data_q <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      rr_last_q  <= rr_last_d;
      rsp_data_q <= rsp_data_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state_q != IDLE);
  assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_bw_mul_arbiter.sv
// Self-checking bench for bw_mul_arbiter. Two instances share the same
// stimulus: one with an 8-bit completion counter, one with a 2-bit counter
// for the wrap check. A negedge monitor keeps a scoreboard of expected
// products pushed at each request handshake and popped on each response.
module tb_bw_mul_arbiter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [W-1:0] x0, y0, x1, y1;
  logic         rsp_ready;
  logic         busy_a, busy_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  bw_mul_arbiter_if #(.WIDTH(W)) bus_a ();
  bw_mul_arbiter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_x0    = x0;
  assign bus_a.req_y0    = y0;
  assign bus_a.req_x1    = x1;
  assign bus_a.req_y1    = y1;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_x0    = x0;
  assign bus_b.req_y0    = y0;
  assign bus_b.req_x1    = x1;
  assign bus_b.req_y1    = y1;
  assign bus_b.rsp_ready = rsp_ready;

  bw_mul_arbiter #(.WIDTH(W), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a), .done_cnt(cnt_a)
  );
  bw_mul_arbiter #(.WIDTH(W), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b), .done_cnt(cnt_b)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   exp;
  } vec_t;

  typedef struct {
    logic       id;
    logic [5:0] data;
  } exp_t;

  exp_t sb_q[$];
  logic grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[5:0];
  endfunction

  // Scoreboard monitor: inputs only change 2 time units after posedge, so
  // at negedge they describe what the next edge will do.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("ready_legal",
            32'((bus_a.req_ready == 2'b11) || ((bus_a.req_ready & ~req_valid) != 2'b00)), 32'd0);
      if (bus_a.rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", 32'(bus_a.rsp_data), 32'(e.data));
          check("sb_id", 32'(bus_a.rsp_id), 32'(e.id));
          check("sb_data_b", 32'(bus_b.rsp_data), 32'(e.data));
        end
      end
      if (req_valid[0] && bus_a.req_ready[0]) begin
        sb_q.push_back('{1'b0, ref_mul(x0, y0)});
        grant_log.push_back(1'b0);
      end
      if (req_valid[1] && bus_a.req_ready[1]) begin
        sb_q.push_back('{1'b1, ref_mul(x1, y1)});
        grant_log.push_back(1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  // Presents one request, waits (bounded) for ready, returns 2 units after
  // the handshake edge N with operands scrambled.
  task automatic accept(input logic id, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    int n;
    if (id) begin x1 = x; y1 = y; end
    else    begin x0 = x; y0 = y; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    n = 0;
    while (!bus_a.req_ready[id] && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({tag, "_accept"}, 32'(bus_a.req_ready[id]), 32'd1);
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    if (id) begin x1 = ~x1; y1 = ~y1; end
    else    begin x0 = ~x0; y0 = ~y0; end
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    check({tag, "_valid_n1"}, 32'(bus_a.rsp_valid), 32'd0);
  endtask

  // Full transaction: accept, product visible after N+1, consumed at N+2.
  task automatic run_vec(input logic id, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [5:0] exp, input string tag);
    accept(id, x, y, tag);
    tick();
    check({tag, "_valid"}, 32'(bus_a.rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(bus_a.rsp_data), 32'(exp));
    check({tag, "_id"}, 32'(bus_a.rsp_id), 32'(id));
    if (rsp_ready) begin
      tick();
      exp_cnt++;
      check({tag, "_valid_drop"}, 32'(bus_a.rsp_valid), 32'd0);
      check({tag, "_cnt"}, 32'(cnt_a), 32'(exp_cnt[7:0]));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [1:0] wrap_exp[5];
    logic [W-1:0] xs, ys;
    int n;

    vecs[0] = '{1'b0, 3'd3,    3'b100, 6'h34};  // 3 * -4
    vecs[1] = '{1'b1, 3'b100,  3'b100, 6'h10};  // -4 * -4
    vecs[2] = '{1'b1, 3'b111,  3'b111, 6'h01};  // -1 * -1
    vecs[3] = '{1'b1, 3'b100,  3'd3,   6'h34};  // -4 * 3
    vecs[4] = '{1'b1, 3'd0,    3'b100, 6'h00};  // 0 * -4
    vecs[5] = '{1'b0, 3'd2,    3'd3,   6'h06};  // 2 * 3
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state, with both requesters already valid.
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    x0 = 3'd1; y0 = 3'd1; x1 = 3'd2; y1 = 3'd2;
    tick(); tick(); tick();
    check("rst_ready", 32'(bus_a.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus_a.rsp_data), 32'd0);
    check("rst_rsp_id", 32'(bus_a.rsp_id), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(bus_a.req_ready), 32'd1);
    req_valid = 2'b00;
    tick();

    // Table vectors: single requester and corner products.
    for (int i = 0; i < 6; i++) run_vec(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].exp, "vec");

    // Full operand sweep on requester 1 against the reference product.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        xs = W'(i);
        ys = W'(j);
        run_vec(1'b1, xs, ys, ref_mul(xs, ys), "sweep");
      end
    end

    // Contention from reset: grants alternate 0,1,0,1.
    apply_reset();
    grant_log.delete();
    x0 = 3'd3; y0 = 3'd2; x1 = 3'b110; y1 = 3'd3;
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    req_valid = 2'b00;
    wait_idle("cont");
    check("cont_grants", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("cont_order", 32'(grant_log[k]), 32'(k % 2));
    exp_cnt += 4;
    check("cont_cnt", 32'(cnt_a), 32'(exp_cnt[7:0]));

    // Backpressure: hold the response for 5 cycles with both requesters valid.
    rsp_ready = 1'b0;
    run_vec(1'b0, 3'b101, 3'd2, 6'h3A, "bp");
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("bp_data", 32'(bus_a.rsp_data), 32'h3A);
      check("bp_id", 32'(bus_a.rsp_id), 32'd0);
      check("bp_ready", 32'(bus_a.req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    check("bp_release_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("bp_release_cnt", 32'(cnt_a), 32'(exp_cnt[7:0]));

    // Reset while in MUL: the last grant went to requester 0.
    accept(1'b0, 3'd3, 3'd3, "rmul");
    rst_n = 1'b0;
    tick();
    exp_cnt = 0;
    check("rmul_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rmul_busy", 32'(busy_a), 32'd0);
    check("rmul_cnt", 32'(cnt_a), 32'd0);
    check("rmul_data", 32'(bus_a.rsp_data), 32'd0);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rmul_regrant", 32'(bus_a.req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    tick();
    check("rmul_no_rsp", 32'(bus_a.rsp_valid), 32'd0);

    // Reset while in RESP holding a product from requester 1.
    run_vec(1'b0, 3'd2, 3'd3, 6'h06, "pre");
    rsp_ready = 1'b0;
    accept(1'b1, 3'd3, 3'd3, "rresp");
    tick();
    check("rresp_in_resp", 32'(bus_a.rsp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    exp_cnt = 0;
    check("rresp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rresp_busy", 32'(busy_a), 32'd0);
    check("rresp_cnt", 32'(cnt_a), 32'd0);
    check("rresp_data", 32'(bus_a.rsp_data), 32'd0);
    check("rresp_id", 32'(bus_a.rsp_id), 32'd0);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rresp_regrant", 32'(bus_a.req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    check("rresp_no_rsp", 32'(bus_a.rsp_valid), 32'd0);

    // Counter wrap on the 2-bit instance.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      xs = W'(k + 1);
      run_vec(k[0], xs, 3'd1, ref_mul(xs, 3'd1), "wrap");
      check("wrap_cnt_b", 32'(cnt_b), 32'(wrap_exp[k]));
    end

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
